// File: rtl/coreuart_fifo_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : coreuart_fifo_sync                                           |
// | Description : Parametrised single-clock FIFO for the CoreUART TX/RX paths.  |
// |               RAM plus wrapping pointers, fill count, live almost-full and  |
// |               almost-empty thresholds, synchronous flush, and one-cycle     |
// |               overflow/underflow pulses.                                    |
// | Ports       : CLK, RESET_N (sync, active-low), CLR (sync flush)             |
// |               WE/DI  - write request and data                               |
// |               RE/DO  - read request and registered read data                |
// |               AF_LEVEL/AE_LEVEL - almost-full / almost-empty thresholds     |
// |               COUNT, FULL, EMPTY, AFULL, AEMPTY - fill status               |
// |               OVERFLOW/UNDERFLOW - dropped write / dropped read pulses      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module coreuart_fifo_sync #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  CLR,
   input  logic                  WE,
   input  logic [WIDTH-1:0]      DI,
   input  logic                  RE,
   output logic [WIDTH-1:0]      DO,
   input  logic [DEPTH_LOG2:0]   AF_LEVEL,
   input  logic [DEPTH_LOG2:0]   AE_LEVEL,
   output logic [DEPTH_LOG2:0]   COUNT,
   output logic                  FULL,
   output logic                  EMPTY,
   output logic                  AFULL,
   output logic                  AEMPTY,
   output logic                  OVERFLOW,
   output logic                  UNDERFLOW
);

   localparam int CW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [CW-1:0] C_DEPTH_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
   logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [WIDTH-1:0]      dout_q, dout_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr_acc;
   logic                  w_rd_acc;

   // Flags come from the registered count, so a word written into an empty
   // FIFO is not visible to the reader until the following cycle.
   assign w_full  = (count_q == C_DEPTH_COUNT);
   assign w_empty = (count_q == '0);

   // A full FIFO still takes a write when a read frees a slot in the same
   // cycle. A flush suppresses both requests.
   assign w_wr_acc = ~CLR & WE & (~w_full | RE);
   assign w_rd_acc = ~CLR & RE & ~w_empty;

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      dout_d      = dout_q;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;

      if (CLR) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
         dout_d  = '0;
      end else begin
         if (w_wr_acc) begin
            wptr_d = wptr_q + DEPTH_LOG2'(1);
         end
         if (w_rd_acc) begin
            rptr_d = rptr_q + DEPTH_LOG2'(1);
            dout_d = mem_q[rptr_q];
         end
         count_d     = count_q + CW'(w_wr_acc) - CW'(w_rd_acc);
         overflow_d  = WE & w_full & ~RE;
         underflow_d = RE & w_empty;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         dout_q      <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         dout_q      <= dout_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is never cleared; only the pointers are reset.
   always_ff @(posedge CLK) begin
      if (RESET_N && w_wr_acc) begin
         mem_q[wptr_q] <= DI;
      end
   end

   assign DO        = dout_q;
   assign COUNT     = count_q;
   assign FULL      = w_full;
   assign EMPTY     = w_empty;
   assign AFULL     = (count_q >= AF_LEVEL);
   assign AEMPTY    = (count_q <= AE_LEVEL);
   assign OVERFLOW  = overflow_q;
   assign UNDERFLOW = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_coreuart_fifo_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_coreuart_fifo_sync                                        |
// | Description : Self-checking bench for coreuart_fifo_sync. Default 256x8     |
// |               instance driven by tables and directed sequences against a   |
// |               queue model; a 16x16 instance driven randomly against its    |
// |               own queue model.                                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_coreuart_fifo_sync;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // ---------------- default instance (WIDTH=8, DEPTH_LOG2=8) ----------------
   logic       rst_n = 1'b0, clr = 1'b0, we = 1'b0, re = 1'b0;
   logic [7:0] di = '0;
   logic [8:0] af = 9'd4, ae = 9'd2;
   logic [7:0] dout;
   logic [8:0] count;
   logic       full, empty, afull, aempty, ovf, unf;

   coreuart_fifo_sync #(.WIDTH(8), .DEPTH_LOG2(8)) u_dut (
      .CLK(clk), .RESET_N(rst_n), .CLR(clr), .WE(we), .DI(di), .RE(re),
      .DO(dout), .AF_LEVEL(af), .AE_LEVEL(ae), .COUNT(count),
      .FULL(full), .EMPTY(empty), .AFULL(afull), .AEMPTY(aempty),
      .OVERFLOW(ovf), .UNDERFLOW(unf)
   );

   // ---------------- small instance (WIDTH=16, DEPTH_LOG2=4) -----------------
   logic        s_rst_n = 1'b0, s_clr = 1'b0, s_we = 1'b0, s_re = 1'b0;
   logic [15:0] s_di = '0;
   logic [4:0]  s_af = 5'd12, s_ae = 5'd3;
   logic [15:0] s_dout;
   logic [4:0]  s_count;
   logic        s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;

   coreuart_fifo_sync #(.WIDTH(16), .DEPTH_LOG2(4)) u_dut_small (
      .CLK(clk), .RESET_N(s_rst_n), .CLR(s_clr), .WE(s_we), .DI(s_di), .RE(s_re),
      .DO(s_dout), .AF_LEVEL(s_af), .AE_LEVEL(s_ae), .COUNT(s_count),
      .FULL(s_full), .EMPTY(s_empty), .AFULL(s_afull), .AEMPTY(s_aempty),
      .OVERFLOW(s_ovf), .UNDERFLOW(s_unf)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   // Reference model of the default instance: a plain queue of stored words.
   logic [7:0] mq[$];
   logic [7:0] m_do  = '0;
   bit         m_ovf = 1'b0, m_unf = 1'b0;

   // One clock cycle on the default instance: drive, predict, clock, compare.
   task automatic cyc(input bit i_we, input bit i_re, input logic [7:0] i_di,
                      input bit i_clr = 1'b0, input bit i_rst_n = 1'b1);
      int sz;
      bit wa, ra;
      @(negedge clk);
      we = i_we; re = i_re; di = i_di; clr = i_clr; rst_n = i_rst_n;
      if (!i_rst_n || i_clr) begin
         mq.delete();
         m_do = '0; m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
         sz    = mq.size();
         wa    = i_we && (sz < 256 || i_re);
         ra    = i_re && (sz > 0);
         m_ovf = i_we && (sz == 256) && !i_re;
         m_unf = i_re && (sz == 0);
         if (ra) m_do = mq.pop_front();
         if (wa) mq.push_back(i_di);
      end
      @(posedge clk);
      #1;
      chk("count",  32'(count),  32'(mq.size()));
      chk("full",   32'(full),   32'(mq.size() == 256));
      chk("empty",  32'(empty),  32'(mq.size() == 0));
      chk("do",     32'(dout),   32'(m_do));
      chk("ovf",    32'(ovf),    32'(m_ovf));
      chk("unf",    32'(unf),    32'(m_unf));
      chk("afull",  32'(afull),  32'(mq.size() >= int'(af)));
      chk("aempty", 32'(aempty), 32'(mq.size() <= int'(ae)));
   endtask

   typedef struct {
      bit         we;
      bit         re;
      logic [8:0] af;
      logic [8:0] ae;
      int         e_count;
      bit         e_afull;
      bit         e_aempty;
      bit         chk_do;
      logic [7:0] e_do;
   } vec_t;

   vec_t tbl[10];

   logic [7:0]  prev_do;
   logic [15:0] sq[$];
   logic [15:0] s_mdo;
   bit          s_mov, s_mun;

   initial begin
      // Threshold vectors, starting from an empty FIFO; row i writes 8'h10+i.
      tbl[0] = '{1'b1, 1'b0, 9'd4, 9'd2,   1, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[1] = '{1'b1, 1'b0, 9'd4, 9'd2,   2, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[2] = '{1'b1, 1'b0, 9'd4, 9'd2,   3, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[3] = '{1'b1, 1'b0, 9'd4, 9'd2,   4, 1'b1, 1'b0, 1'b0, 8'h00};
      tbl[4] = '{1'b1, 1'b0, 9'd4, 9'd2,   5, 1'b1, 1'b0, 1'b0, 8'h00};
      tbl[5] = '{1'b0, 1'b0, 9'd6, 9'd2,   5, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[6] = '{1'b0, 1'b0, 9'd0, 9'd2,   5, 1'b1, 1'b0, 1'b0, 8'h00};
      tbl[7] = '{1'b0, 1'b0, 9'd6, 9'd300, 5, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[8] = '{1'b0, 1'b1, 9'd6, 9'd2,   4, 1'b0, 1'b0, 1'b1, 8'h10};
      tbl[9] = '{1'b0, 1'b1, 9'd4, 9'd2,   3, 1'b0, 1'b0, 1'b1, 8'h11};

      // Reset state.
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full",  32'(full),  32'd0);
      chk("rst_do",    32'(dout),  32'd0);
      chk("rst_ovf",   32'(ovf),   32'd0);

      // Thresholds, table-driven.
      for (int i = 0; i < 10; i++) begin
         af = tbl[i].af;
         ae = tbl[i].ae;
         cyc(tbl[i].we, tbl[i].re, 8'(8'h10 + i));
         chk("tbl_count",  32'(count),  32'(tbl[i].e_count));
         chk("tbl_afull",  32'(afull),  32'(tbl[i].e_afull));
         chk("tbl_aempty", 32'(aempty), 32'(tbl[i].e_aempty));
         if (tbl[i].chk_do) chk("tbl_do", 32'(dout), 32'(tbl[i].e_do));
      end
      // Threshold change acts without a clock edge (count is 3 here).
      af = 9'd3; #1;
      chk("af_live_hi", 32'(afull), 32'd1);
      af = 9'd4; #1;
      chk("af_live_lo", 32'(afull), 32'd0);

      // Fill and overflow.
      af = 9'd255; ae = 9'd0;
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 256; i++) cyc(1'b1, 1'b0, 8'(i));
      chk("fill_count", 32'(count), 32'd256);
      chk("fill_full",  32'(full),  32'd1);
      chk("fill_afull", 32'(afull), 32'd1);
      cyc(1'b1, 1'b0, 8'h77);
      chk("ovf_pulse", 32'(ovf),   32'd1);
      chk("ovf_count", 32'(count), 32'd256);
      cyc(1'b0, 1'b0, 8'h00);
      chk("ovf_single", 32'(ovf), 32'd0);
      // Write into a full FIFO alongside a read.
      cyc(1'b1, 1'b1, 8'hEE);
      chk("fullrw_ovf",   32'(ovf),   32'd0);
      chk("fullrw_count", 32'(count), 32'd256);
      chk("fullrw_do",    32'(dout),  32'h00);
      for (int i = 1; i < 256; i++) begin
         cyc(1'b0, 1'b1, 8'h00);
         chk("drain_do", 32'(dout), 32'(i));
      end
      cyc(1'b0, 1'b1, 8'h00);
      chk("drain_last", 32'(dout),  32'hEE);
      chk("drain_empty", 32'(empty), 32'd1);

      // Underflow for three cycles; DO holds.
      prev_do = dout;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 8'h00);
         chk("unf_pulse", 32'(unf),   32'd1);
         chk("unf_do",    32'(dout),  32'(prev_do));
         chk("unf_count", 32'(count), 32'd0);
      end
      cyc(1'b0, 1'b0, 8'h00);
      chk("unf_clear", 32'(unf), 32'd0);

      // Simultaneous read and write at count 5.
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h30 + i));
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 1'b1, 8'(8'h40 + i));
         chk("rw_count", 32'(count), 32'd5);
      end
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h00);
      chk("rw_last", 32'(dout), 32'h49);

      // CLR mid-operation.
      for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 8'(i + 1));
      cyc(1'b0, 1'b1, 8'h00);
      cyc(1'b1, 1'b0, 8'h65);
      chk("pre_clr_count", 32'(count), 32'd100);
      cyc(1'b1, 1'b0, 8'h55, 1'b1, 1'b1);
      chk("clr_count", 32'(count), 32'd0);
      chk("clr_empty", 32'(empty), 32'd1);
      chk("clr_do",    32'(dout),  32'd0);
      cyc(1'b0, 1'b0, 8'h00);
      chk("clr_nowr", 32'(empty), 32'd1);

      // Reset mid-operation.
      for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, 8'(i + 2));
      cyc(1'b0, 1'b1, 8'h00);
      chk("pre_rst_do", 32'(dout), 32'h02);
      cyc(1'b1, 1'b0, 8'h66, 1'b0, 1'b0);
      chk("mrst_do",    32'(dout),  32'd0);
      chk("mrst_count", 32'(count), 32'd0);
      cyc(1'b1, 1'b0, 8'hA5);
      cyc(1'b0, 1'b1, 8'h00);
      chk("a5_do", 32'(dout), 32'hA5);

      // Random interleaving on the 16x16 instance against its own queue.
      @(negedge clk);
      s_rst_n = 1'b0;
      @(posedge clk);
      #1;
      s_mdo = '0;
      for (int n = 0; n < 300; n++) begin
         int  sz;
         bit  wa, ra;
         @(negedge clk);
         s_rst_n = 1'b1;
         s_we = ($urandom_range(0, 99) < 55);
         s_re = ($urandom_range(0, 99) < 45);
         s_di = 16'($urandom);
         sz    = sq.size();
         wa    = s_we && (sz < 16 || s_re);
         ra    = s_re && (sz > 0);
         s_mov = s_we && (sz == 16) && !s_re;
         s_mun = s_re && (sz == 0);
         if (ra) s_mdo = sq.pop_front();
         if (wa) sq.push_back(s_di);
         @(posedge clk);
         #1;
         chk("s_count",  32'(s_count),  32'(sq.size()));
         chk("s_do",     32'(s_dout),   32'(s_mdo));
         chk("s_full",   32'(s_full),   32'(sq.size() == 16));
         chk("s_empty",  32'(s_empty),  32'(sq.size() == 0));
         chk("s_ovf",    32'(s_ovf),    32'(s_mov));
         chk("s_unf",    32'(s_unf),    32'(s_mun));
         chk("s_afull",  32'(s_afull),  32'(sq.size() >= 12));
         chk("s_aempty", 32'(s_aempty), 32'(sq.size() <= 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
